vx_dcache_port_adapter: RTL and testbench
=========================================

Name: vx_dcache_port_adapter

Overview:
- Warp-wide data-cache request adapter between the execute/LSU stage and the per-lane dcache ports, at the pipeline's memory boundary.
- Buffers whole-warp requests in a queue and issues each lane independently, tolerating partial per-lane ready.
- Tracks outstanding load lanes to bound in-flight traffic and drive `busy_o`.
- Provides a drain-then-acknowledge sleep handshake, so the core can only sleep with an idle memory port.

Parameters:
- NUM_LANES, 4, threads per warp request; >=1.
- WORD_SIZE, 4, bytes per lane word.
- ADDR_WIDTH, 30, word address width.
- TAG_WIDTH, 8, request/response tag width.
- QUEUE_DEPTH, 4, warp-request queue entries; power of two, >=2.
- MAX_OUTSTANDING, 16, maximum in-flight load lanes; must be >= NUM_LANES.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_req_valid  in  1  warp request valid.
- core_req_rw  in  1  1=store, 0=load.
- core_req_tmask  in  NUM_LANES  active lanes.
- core_req_byteen  in  NUM_LANES*WORD_SIZE  per-lane byte enables.
- core_req_addr  in  NUM_LANES*ADDR_WIDTH  per-lane word address.
- core_req_data  in  NUM_LANES*8*WORD_SIZE  per-lane store data.
- core_req_tag  in  TAG_WIDTH  request tag.
- core_req_ready  out  1  request accepted when valid&ready.
- dcache_req_valid  out  NUM_LANES  per-lane request valid.
- dcache_req_rw / dcache_req_byteen / dcache_req_addr / dcache_req_data / dcache_req_tag  out  per-lane copies of the head entry fields.
- dcache_req_ready  in  NUM_LANES  per-lane accept.
- dcache_rsp_valid, dcache_rsp_tmask[NUM_LANES], dcache_rsp_data[NUM_LANES*8*WORD_SIZE], dcache_rsp_tag[TAG_WIDTH]  in  dcache response.
- dcache_rsp_ready  out  1  equals core_rsp_ready.
- core_rsp_valid, core_rsp_tmask, core_rsp_data, core_rsp_tag  out  combinational pass-through of dcache_rsp_*.
- core_rsp_ready  in  1  core accepts response.
- sleep_req_i  in  1  level request to enter sleep.
- sleep_ack_o  out  1  port drained and sleeping.
- busy_o  out  1  queue non-empty or loads outstanding.

Behaviour:
- Reset (reset=0, asynchronous):
  - Queue empty, sent mask 0, outstanding counter 0, FSM=RUN.
  - All dcache_req_valid=0, sleep_ack_o=0, busy_o=0.
  - core_req_ready becomes 1 once reset is released.
- Enqueue:
  - core_req_ready = !full & (state==RUN).
  - A request with tmask==0 is accepted and discarded, never enqueued.
  - No bypass: an entry enqueued at cycle N drives dcache_req_valid no earlier than N+1.
- Issue (head entry):
  - lane_pend[i] = head_valid & tmask[i] & !sent[i].
  - dcache_req_valid[i] = lane_pend[i] & issue_en.
  - issue_en = (outstanding + NUM_LANES <= MAX_OUTSTANDING) (conservative gate).
  - lane_fire = dcache_req_valid & dcache_req_ready; sent |= lane_fire.
- Retire:
  - The head pops in the cycle where (sent | lane_fire | ~tmask) is all ones. sent clears to 0 in that same cycle.
  - The next entry's lanes are valid the following cycle.
  - Push and pop may occur in the same cycle when not full.
- Outstanding counter (width clog2(MAX_OUTSTANDING+1)):
  - next = cnt + popcount(lane_fire & {NUM_LANES{!head_rw}}) - popcount(dcache_rsp_tmask when dcache_rsp_valid & core_rsp_ready).
  - Simultaneous increment and decrement net in one cycle.
  - Stores generate no response and are not counted.
  - Underflow is a simulation assertion error.
- busy_o = !empty | (cnt != 0), registered-state derived, no combinational input path.
- Sleep FSM:
  - RUN: sleep_req_i=1 -> DRAIN.
  - DRAIN: core_req_ready=0; queued entries still issue and responses still return. sleep_req_i=0 -> RUN. Otherwise empty & cnt==0 -> SLEEP.
  - SLEEP: sleep_ack_o=1, core_req_ready=0. sleep_req_i=0 -> RUN next cycle, and ack drops in that cycle.
  - A sleep request while already idle reaches SLEEP in 2 cycles (RUN->DRAIN->SLEEP).
- Response path is purely combinational; the block adds no buffering and no reordering.

Decomposition:
- Package vx_dcache_port_pkg:
  - state_e enum {RUN, DRAIN, SLEEP}.
  - Popcount function.
  - Parameter-check macros.
- Sub-module vx_dcache_port_fifo: generic DEPTH×WIDTH synchronous FIFO with full/empty, async active-low reset. It stores the packed {rw, tmask, byteen, addr, data, tag} entry.

Test Plan:
- NUM_LANES=4, load tmask=4'b1011, all ready=1 -> lanes 0,1,3 valid for one cycle 1 cycle after accept. Head pops; outstanding=3. Response with tmask=4'b1011 -> outstanding=0, busy_o=0.
- Partial ready: cycle1 ready=4'b0001, cycle2 ready=4'b1110, tmask=4'hF -> lane0 issues once (not reissued in cycle2); pop at cycle2; next entry valid at cycle3.
- Queue fill: 5 back-to-back requests with dcache_req_ready=0, QUEUE_DEPTH=4 -> core_req_ready=0 after the 4th accept. Releasing ready drains them in order, 1 entry per cycle.
- Outstanding cap: MAX_OUTSTANDING=8, two full-mask loads with no responses -> cnt=8 and the third entry's lanes stay invalid. One 4-lane response -> cnt=4, and the third entry issues the next cycle.
- Sleep: 2 outstanding loads, sleep_req_i=1 -> core_req_ready=0 and sleep_ack_o=0 until the last response, then sleep_ack_o=1 the next cycle. Dropping sleep_req_i -> ack=0 and core_req_ready=1 next cycle.
- Async reset asserted mid-DRAIN with 2 queued entries -> all outputs 0 immediately; after release, queue empty, cnt=0, state RUN.

Source files
------------

// File: rtl/vx_dcache_port_pkg.sv
// Shared types and helpers for the warp-wide dcache port adapter.
// Provides the sleep FSM state type, a lane popcount helper, and a
// parameter-check macro that raises an elaboration error on bad settings.
`ifndef VX_DCACHE_PORT_PKG_SV
`define VX_DCACHE_PORT_PKG_SV

`define VX_PARAM_CHECK(label, cond) \
  if (!(cond)) begin : label \
    $error("vx_dcache_port: parameter constraint violated"); \
  end

package vx_dcache_port_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2
  } state_e;

  // Lane masks are zero-extended into a 32-bit word, so NUM_LANES <= 32.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

`endif

// File: rtl/vx_dcache_port_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO; head entry visible combinationally.
// Latency: a push is visible at the head the cycle after it is written (no bypass).
// Backpressure: caller must not push when full nor pop when empty.
// Ports: clk, rst_n (async active-low), push_vld/push_dat, pop, head_dat, full, empty.
module vx_dcache_port_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra wrap bit distinguishes full from empty when indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/vx_dcache_port_adapter.sv
// Queues warp-wide LSU requests and issues each lane to its dcache port independently.
// Latency: an accepted request drives dcache_req_valid one cycle later at the earliest.
// Backpressure: core_req_ready drops when the queue is full or while draining/sleeping;
//   lanes stall individually on dcache_req_ready and all lanes stall on the load cap.
// Ports: core_req_* (warp request in), dcache_req_* (per-lane out), dcache_rsp_* ->
//   core_rsp_* (combinational pass-through), sleep_req_i/sleep_ack_o, busy_o.
module vx_dcache_port_adapter
  import vx_dcache_port_pkg::*;
#(
  parameter int NUM_LANES       = 4,
  parameter int WORD_SIZE       = 4,
  parameter int ADDR_WIDTH      = 30,
  parameter int TAG_WIDTH       = 8,
  parameter int QUEUE_DEPTH     = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              core_req_valid,
  input  logic                              core_req_rw,
  input  logic [NUM_LANES-1:0]              core_req_tmask,
  input  logic [NUM_LANES*WORD_SIZE-1:0]    core_req_byteen,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0]   core_req_addr,
  input  logic [NUM_LANES*8*WORD_SIZE-1:0]  core_req_data,
  input  logic [TAG_WIDTH-1:0]              core_req_tag,
  output logic                              core_req_ready,
  output logic [NUM_LANES-1:0]              dcache_req_valid,
  output logic [NUM_LANES-1:0]              dcache_req_rw,
  output logic [NUM_LANES*WORD_SIZE-1:0]    dcache_req_byteen,
  output logic [NUM_LANES*ADDR_WIDTH-1:0]   dcache_req_addr,
  output logic [NUM_LANES*8*WORD_SIZE-1:0]  dcache_req_data,
  output logic [NUM_LANES*TAG_WIDTH-1:0]    dcache_req_tag,
  input  logic [NUM_LANES-1:0]              dcache_req_ready,
  input  logic                              dcache_rsp_valid,
  input  logic [NUM_LANES-1:0]              dcache_rsp_tmask,
  input  logic [NUM_LANES*8*WORD_SIZE-1:0]  dcache_rsp_data,
  input  logic [TAG_WIDTH-1:0]              dcache_rsp_tag,
  output logic                              dcache_rsp_ready,
  output logic                              core_rsp_valid,
  output logic [NUM_LANES-1:0]              core_rsp_tmask,
  output logic [NUM_LANES*8*WORD_SIZE-1:0]  core_rsp_data,
  output logic [TAG_WIDTH-1:0]              core_rsp_tag,
  input  logic                              core_rsp_ready,
  input  logic                              sleep_req_i,
  output logic                              sleep_ack_o,
  output logic                              busy_o
);
  localparam int BYTEEN_W = NUM_LANES * WORD_SIZE;
  localparam int ADDR_W   = NUM_LANES * ADDR_WIDTH;
  localparam int DATA_W   = NUM_LANES * 8 * WORD_SIZE;
  localparam int ENTRY_W  = 1 + NUM_LANES + BYTEEN_W + ADDR_W + DATA_W + TAG_WIDTH;
  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  // Issue only if a whole warp of loads could still fit under the cap.
  localparam logic [CNT_W-1:0] ISSUE_LIMIT = CNT_W'(MAX_OUTSTANDING - NUM_LANES);

  `VX_PARAM_CHECK(g_chk_lanes, (NUM_LANES >= 1) && (NUM_LANES <= 32))
  `VX_PARAM_CHECK(g_chk_depth, (QUEUE_DEPTH >= 2) && ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) == 0))
  `VX_PARAM_CHECK(g_chk_outst, MAX_OUTSTANDING >= NUM_LANES)

  state_e               state_q, state_d;
  logic [NUM_LANES-1:0] sent_q, sent_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, inc, dec;

  logic                 fifo_full, fifo_empty, push, pop;
  logic [ENTRY_W-1:0]   push_dat, head_dat;

  logic                 head_rw;
  logic [NUM_LANES-1:0] head_tmask;
  logic [BYTEEN_W-1:0]  head_byteen;
  logic [ADDR_W-1:0]    head_addr;
  logic [DATA_W-1:0]    head_data;
  logic [TAG_WIDTH-1:0] head_tag;

  logic                 issue_en;
  logic [NUM_LANES-1:0] lane_pend, lane_fire;
  logic [CNT_W:0]       cnt_plus_inc;

  // Empty-mask requests are acknowledged but never occupy a queue slot.
  assign push     = core_req_valid & core_req_ready & (|core_req_tmask);
  assign push_dat = {core_req_rw, core_req_tmask, core_req_byteen,
                     core_req_addr, core_req_data, core_req_tag};

  vx_dcache_port_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push_vld (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign {head_rw, head_tmask, head_byteen, head_addr, head_data, head_tag} = head_dat;

  assign issue_en         = (cnt_q <= ISSUE_LIMIT);
  assign lane_pend        = {NUM_LANES{~fifo_empty}} & head_tmask & ~sent_q;
  assign dcache_req_valid = lane_pend & {NUM_LANES{issue_en}};
  assign lane_fire        = dcache_req_valid & dcache_req_ready;

  assign dcache_req_rw     = {NUM_LANES{head_rw}};
  assign dcache_req_byteen = head_byteen;
  assign dcache_req_addr   = head_addr;
  assign dcache_req_data   = head_data;
  assign dcache_req_tag    = {NUM_LANES{head_tag}};

  // Head retires once every active lane has gone out, counting this cycle's fires.
  assign pop    = ~fifo_empty & (&(sent_q | lane_fire | ~head_tmask));
  assign sent_d = pop ? '0 : (sent_q | lane_fire);

  // Only loads expect a response; stores leave the counter alone.
  assign inc   = CNT_W'(popcount(32'(lane_fire & {NUM_LANES{~head_rw}})));
  assign dec   = (dcache_rsp_valid & core_rsp_ready) ? CNT_W'(popcount(32'(dcache_rsp_tmask))) : '0;
  assign cnt_d = cnt_q + inc - dec;

  assign cnt_plus_inc = {1'b0, cnt_q} + {1'b0, inc};

  assert property (@(posedge clk) disable iff (!reset) cnt_plus_inc >= {1'b0, dec})
    else $error("vx_dcache_port_adapter: outstanding load counter underflow");

  assign dcache_rsp_ready = core_rsp_ready;
  assign core_rsp_valid   = dcache_rsp_valid;
  assign core_rsp_tmask   = dcache_rsp_tmask;
  assign core_rsp_data    = dcache_rsp_data;
  assign core_rsp_tag     = dcache_rsp_tag;

  assign busy_o = ~fifo_empty | (cnt_q != '0);

  // DRAIN looks at the next counter value so the ack follows the last
  // response by exactly one cycle.
  always_comb begin
    state_d        = state_q;
    core_req_ready = 1'b0;
    sleep_ack_o    = 1'b0;
    unique case (state_q)
      RUN: begin
        core_req_ready = reset & ~fifo_full;
        if (sleep_req_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!sleep_req_i)                      state_d = RUN;
        else if (fifo_empty && cnt_d == '0)    state_d = SLEEP;
      end
      SLEEP: begin
        sleep_ack_o = 1'b1;
        if (!sleep_req_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      sent_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_vx_dcache_port_adapter.sv
// Randomized and directed stimulus for vx_dcache_port_adapter, checked every
// cycle against a queue-based reference model of the adapter's behaviour.
module tb_vx_dcache_port_adapter;
  localparam int NL = 4;
  localparam int WS = 4;
  localparam int AW = 30;
  localparam int TW = 8;
  localparam int QD = 4;
  localparam int MO = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 core_req_valid, core_req_rw;
  logic [NL-1:0]        core_req_tmask;
  logic [NL*WS-1:0]     core_req_byteen;
  logic [NL*AW-1:0]     core_req_addr;
  logic [NL*8*WS-1:0]   core_req_data;
  logic [TW-1:0]        core_req_tag;
  logic                 core_req_ready;
  logic [NL-1:0]        dcache_req_valid, dcache_req_rw, dcache_req_ready;
  logic [NL*WS-1:0]     dcache_req_byteen;
  logic [NL*AW-1:0]     dcache_req_addr;
  logic [NL*8*WS-1:0]   dcache_req_data;
  logic [NL*TW-1:0]     dcache_req_tag;
  logic                 dcache_rsp_valid, dcache_rsp_ready;
  logic [NL-1:0]        dcache_rsp_tmask;
  logic [NL*8*WS-1:0]   dcache_rsp_data;
  logic [TW-1:0]        dcache_rsp_tag;
  logic                 core_rsp_valid, core_rsp_ready;
  logic [NL-1:0]        core_rsp_tmask;
  logic [NL*8*WS-1:0]   core_rsp_data;
  logic [TW-1:0]        core_rsp_tag;
  logic                 sleep_req_i, sleep_ack_o, busy_o;

  vx_dcache_port_adapter #(
    .NUM_LANES(NL), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
    .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_rw(core_req_rw),
    .core_req_tmask(core_req_tmask), .core_req_byteen(core_req_byteen),
    .core_req_addr(core_req_addr), .core_req_data(core_req_data),
    .core_req_tag(core_req_tag), .core_req_ready(core_req_ready),
    .dcache_req_valid(dcache_req_valid), .dcache_req_rw(dcache_req_rw),
    .dcache_req_byteen(dcache_req_byteen), .dcache_req_addr(dcache_req_addr),
    .dcache_req_data(dcache_req_data), .dcache_req_tag(dcache_req_tag),
    .dcache_req_ready(dcache_req_ready),
    .dcache_rsp_valid(dcache_rsp_valid), .dcache_rsp_tmask(dcache_rsp_tmask),
    .dcache_rsp_data(dcache_rsp_data), .dcache_rsp_tag(dcache_rsp_tag),
    .dcache_rsp_ready(dcache_rsp_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp_tmask(core_rsp_tmask),
    .core_rsp_data(core_rsp_data), .core_rsp_tag(core_rsp_tag),
    .core_rsp_ready(core_rsp_ready),
    .sleep_req_i(sleep_req_i), .sleep_ack_o(sleep_ack_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rw;
    logic [NL-1:0]     tmask;
    logic [NL*WS-1:0]  byteen;
    logic [NL*AW-1:0]  addr;
    logic [NL*8*WS-1:0] data;
    logic [TW-1:0]     tag;
  } ent_t;

  // Reference model: the queue of accepted warp requests, which lanes of the
  // oldest one have been handed out, and how many load lanes await a reply.
  ent_t          q[$];
  logic [NL-1:0] m_sent;
  int            m_outst;
  bit            m_draining, m_sleeping;

  int n_cmp = 0;
  int n_err = 0;
  bit slp_r = 1'b0;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_sent     = '0;
    m_outst    = 0;
    m_draining = 1'b0;
    m_sleeping = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, compare the DUT against
  // the model mid-cycle, then advance the model to the post-edge state.
  task automatic step(input bit vld, input bit rw, input logic [NL-1:0] tm,
                      input logic [NL-1:0] rdy, input bit rv, input logic [NL-1:0] rm,
                      input bit rr, input bit slp);
    ent_t          e;
    logic [127:0]  r;
    logic [NL-1:0] rmask, exp_vld, fire;
    logic [127:0]  rdata;
    logic [TW-1:0] rtag;
    bit            exp_rdy, was_empty;
    int            inc, dec;
    @(negedge clk);
    rmask = rm;
    while ($countones(rmask) > m_outst) rmask = rmask & (rmask - 4'd1);
    e.rw = rw;
    e.tmask = tm;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    e.byteen = r[NL*WS-1:0];
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    e.addr = r[NL*AW-1:0];
    e.data = {$urandom(), $urandom(), $urandom(), $urandom()};
    r = {96'd0, $urandom()};
    e.tag = r[TW-1:0];
    rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    rtag  = r[TW+7:8];
    core_req_valid = vld;     core_req_rw = e.rw;       core_req_tmask = e.tmask;
    core_req_byteen = e.byteen; core_req_addr = e.addr; core_req_data = e.data;
    core_req_tag = e.tag;     dcache_req_ready = rdy;
    dcache_rsp_valid = rv;    dcache_rsp_tmask = rmask; dcache_rsp_data = rdata;
    dcache_rsp_tag = rtag;    core_rsp_ready = rr;      sleep_req_i = slp;
    #1;
    exp_rdy = (q.size() < QD) && !m_draining && !m_sleeping;
    exp_vld = '0;
    if (q.size() > 0 && m_outst + NL <= MO) exp_vld = q[0].tmask & ~m_sent;
    chk_eq("req_ready", 128'(core_req_ready), 128'(exp_rdy));
    chk_eq("req_valid", 128'(dcache_req_valid), 128'(exp_vld));
    chk_eq("busy", 128'(busy_o), 128'(q.size() > 0 || m_outst != 0));
    chk_eq("sleep_ack", 128'(sleep_ack_o), 128'(m_sleeping));
    chk_eq("rsp_valid", 128'(core_rsp_valid), 128'(rv));
    chk_eq("rsp_ready", 128'(dcache_rsp_ready), 128'(rr));
    chk_eq("rsp_tmask", 128'(core_rsp_tmask), 128'(rmask));
    chk_eq("rsp_data", core_rsp_data, rdata);
    chk_eq("rsp_tag", 128'(core_rsp_tag), 128'(rtag));
    if (q.size() > 0) begin
      chk_eq("lane_rw", 128'(dcache_req_rw), 128'({NL{q[0].rw}}));
      chk_eq("lane_byteen", 128'(dcache_req_byteen), 128'(q[0].byteen));
      chk_eq("lane_addr", 128'(dcache_req_addr), 128'(q[0].addr));
      chk_eq("lane_data", dcache_req_data, q[0].data);
      chk_eq("lane_tag", 128'(dcache_req_tag), 128'({NL{q[0].tag}}));
    end
    fire = exp_vld & rdy;
    inc = 0;
    was_empty = (q.size() == 0);
    if (!was_empty) begin
      if (!q[0].rw) inc = $countones(fire);
      m_sent = m_sent | fire;
      if ((m_sent | ~q[0].tmask) == '1) begin
        void'(q.pop_front());
        m_sent = '0;
      end
    end
    if (vld && exp_rdy && tm != '0) q.push_back(e);
    dec = (rv && rr) ? $countones(rmask) : 0;
    m_outst = m_outst + inc - dec;
    if (m_sleeping) begin
      if (!slp) m_sleeping = 1'b0;
    end else if (m_draining) begin
      if (!slp) m_draining = 1'b0;
      else if (was_empty && m_outst == 0) begin
        m_draining = 1'b0;
        m_sleeping = 1'b1;
      end
    end else if (slp) begin
      m_draining = 1'b1;
    end
  endtask

  task automatic idle(input int n, input logic [NL-1:0] rdy);
    for (int i = 0; i < n; i++) step(0, 0, '0, rdy, 0, '0, 1, 0);
  endtask

  initial begin
    reset = 1'b0;
    core_req_valid = 0; core_req_rw = 0; core_req_tmask = '0; core_req_byteen = '0;
    core_req_addr = '0; core_req_data = '0; core_req_tag = '0; dcache_req_ready = '0;
    dcache_rsp_valid = 0; dcache_rsp_tmask = '0; dcache_rsp_data = '0; dcache_rsp_tag = '0;
    core_rsp_ready = 0; sleep_req_i = 0;
    model_reset();
    #2;
    chk_eq("rst_req_valid", 128'(dcache_req_valid), 128'(0));
    chk_eq("rst_sleep_ack", 128'(sleep_ack_o), 128'(0));
    chk_eq("rst_busy", 128'(busy_o), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single load, mask 1011, all lanes ready, then its response.
    step(1, 0, 4'b1011, 4'hF, 0, '0, 1, 0);
    chk_eq("t1_ready_after_reset", 128'(core_req_ready), 128'(1));
    step(0, 0, '0, 4'hF, 0, '0, 1, 0);
    chk_eq("t1_lanes", 128'(dcache_req_valid), 128'(4'b1011));
    step(0, 0, '0, 4'hF, 1, 4'b1011, 1, 0);
    step(0, 0, '0, 4'hF, 0, '0, 1, 0);
    chk_eq("t1_busy_clear", 128'(busy_o), 128'(0));

    // Partial lane ready across two cycles; second entry follows.
    step(1, 0, 4'hF, 4'h0, 0, '0, 1, 0);
    step(1, 0, 4'b0011, 4'b0001, 0, '0, 1, 0);
    step(0, 0, '0, 4'b1110, 0, '0, 1, 0);
    chk_eq("t2_no_reissue", 128'(dcache_req_valid), 128'(4'b1110));
    step(0, 0, '0, 4'hF, 0, '0, 1, 0);
    step(0, 0, '0, 4'hF, 1, 4'hF, 1, 0);
    step(0, 0, '0, 4'hF, 1, 4'b0011, 1, 0);

    // Queue fill with stores while the dcache refuses everything.
    for (int i = 0; i < 5; i++) step(1, 1, 4'hF, 4'h0, 0, '0, 1, 0);
    chk_eq("t3_full", 128'(core_req_ready), 128'(0));
    for (int i = 0; i < 6; i++) step(i == 0, 1, 4'hF, 4'hF, 0, '0, 1, 0);

    // Outstanding cap: two full loads fill it, the third waits for a reply.
    for (int i = 0; i < 3; i++) step(1, 0, 4'hF, 4'hF, 0, '0, 1, 0);
    idle(3, 4'hF);
    chk_eq("t4_capped", 128'(dcache_req_valid), 128'(0));
    step(0, 0, '0, 4'hF, 1, 4'hF, 1, 0);
    step(0, 0, '0, 4'hF, 0, '0, 1, 0);
    chk_eq("t4_uncapped", 128'(dcache_req_valid), 128'(4'hF));
    step(0, 0, '0, 4'hF, 1, 4'hF, 1, 0);
    step(0, 0, '0, 4'hF, 1, 4'hF, 1, 0);

    // Sleep while two load lanes are still out.
    step(1, 0, 4'b0011, 4'hF, 0, '0, 1, 0);
    step(0, 0, '0, 4'hF, 0, '0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 4'hF, 0, '0, 1, 1);
    chk_eq("t5_drain_ready", 128'(core_req_ready), 128'(0));
    step(0, 0, '0, 4'hF, 1, 4'b0011, 1, 1);
    step(0, 0, '0, 4'hF, 0, '0, 1, 1);
    chk_eq("t5_ack", 128'(sleep_ack_o), 128'(1));
    step(0, 0, '0, 4'hF, 0, '0, 1, 0);
    step(0, 0, '0, 4'hF, 0, '0, 1, 0);
    chk_eq("t5_wake_ready", 128'(core_req_ready), 128'(1));

    // Randomized traffic with occasional sleep requests.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) slp_r = !slp_r;
      step($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, 4'($urandom()),
           4'($urandom()), $urandom_range(0, 2) == 0, 4'($urandom()),
           $urandom_range(0, 3) != 0, slp_r);
    end
    for (int c = 0; c < 40; c++) step(0, 0, '0, 4'hF, 1, 4'hF, 1, 0);
    chk_eq("rand_idle", 128'(busy_o), 128'(0));

    // Asynchronous reset in the middle of a drain with two entries queued.
    step(1, 0, 4'hF, 4'h0, 0, '0, 1, 0);
    step(1, 0, 4'b0101, 4'h0, 0, '0, 1, 0);
    step(0, 0, '0, 4'h0, 0, '0, 1, 1);
    step(0, 0, '0, 4'h0, 0, '0, 1, 1);
    chk_eq("t6_busy_before", 128'(busy_o), 128'(1));
    core_req_valid = 0; dcache_rsp_valid = 0; dcache_rsp_tmask = '0;
    dcache_rsp_data = '0; dcache_rsp_tag = '0; sleep_req_i = 0;
    #2 reset = 1'b0;
    #1;
    chk_eq("t6_req_valid", 128'(dcache_req_valid), 128'(0));
    chk_eq("t6_sleep_ack", 128'(sleep_ack_o), 128'(0));
    chk_eq("t6_busy", 128'(busy_o), 128'(0));
    chk_eq("t6_req_ready", 128'(core_req_ready), 128'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    idle(3, 4'hF);
    step(1, 0, 4'b1000, 4'hF, 0, '0, 1, 0);
    step(0, 0, '0, 4'hF, 0, '0, 1, 0);
    chk_eq("t6_after", 128'(dcache_req_valid), 128'(4'b1000));
    step(0, 0, '0, 4'hF, 1, 4'b0001, 1, 0);
    idle(2, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
